// File: rtl/poly_pkg.sv
// Shared types and helpers for the polynomial pipeline blocks.
package poly_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SQ,
        CU,
        CMP
    } cube_root_state_t;

    function automatic int cube_root_w(input int w);
        return (w + 2) / 3;
    endfunction

endpackage

// File: rtl/seq_cube_root.sv
// Bit-serial integer cube root: one root bit per SQ/CU/CMP round, MSB first,
// on a single shared multiplier. Yields floor(cbrt(y)) and y - root^3.
module seq_cube_root
    import poly_pkg::*;
#(
    parameter  int unsigned W = 6,
    localparam int unsigned R = $unsigned(cube_root_w(int'(W)))
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] y_in,
    output logic [R-1:0] root_out,
    output logic [W-1:0] rem_out,
    output logic         finish
);

    localparam int unsigned IW = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned PW = 3 * R;

    cube_root_state_t r_state;
    cube_root_state_t w_state_nxt;

    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_y;
    logic [R-1:0]  r_root;
    logic [PW-1:0] r_cube_acc;
    logic [PW-1:0] r_prod;
    logic [R-1:0]  r_root_out;
    logic [W-1:0]  r_rem_out;
    logic          r_finish;

    logic [R-1:0]  w_cand;
    logic [PW-1:0] w_mul_b;
    logic [PW-1:0] w_mul;
    logic          w_fits;
    logic [R-1:0]  w_root_nxt;
    logic [PW-1:0] w_acc_nxt;

    // Shared multiplier: squares the candidate in SQ, cubes it in CU.
    // (2^R-1)^3 fits in 3R bits, so the truncation never loses data.
    assign w_cand     = r_root | (R'(1) << r_idx);
    assign w_mul_b    = (r_state == SQ) ? PW'(w_cand) : r_prod;
    assign w_mul      = PW'(w_cand) * w_mul_b;
    assign w_fits     = (r_prod <= PW'(r_y));
    assign w_root_nxt = w_fits ? w_cand : r_root;
    assign w_acc_nxt  = w_fits ? r_prod : r_cube_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SQ;
            SQ:      w_state_nxt = CU;
            CU:      w_state_nxt = CMP;
            CMP:     w_state_nxt = (r_idx == '0) ? IDLE : SQ;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_y        <= '0;
            r_root     <= '0;
            r_cube_acc <= '0;
            r_prod     <= '0;
            r_root_out <= '0;
            r_rem_out  <= '0;
            r_finish   <= 1'b1;
        end else begin
            r_finish <= (w_state_nxt == IDLE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_y        <= y_in;
                        r_root     <= '0;
                        r_cube_acc <= '0;
                        r_idx      <= IW'(R - 1);
                    end
                end
                SQ, CU: r_prod <= w_mul;
                CMP: begin
                    r_root     <= w_root_nxt;
                    r_cube_acc <= w_acc_nxt;
                    // Publish results only when the last bit is resolved.
                    if (r_idx == '0) begin
                        r_root_out <= w_root_nxt;
                        r_rem_out  <= r_y - W'(w_acc_nxt);
                    end else begin
                        r_idx <= r_idx - IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign root_out = r_root_out;
    assign rem_out  = r_rem_out;
    assign finish   = r_finish;

`ifndef SYNTHESIS
    a_finish_idle: assert property (@(posedge clk) disable iff (rst)
        r_finish == (r_state == IDLE));
    a_acc_le_y: assert property (@(posedge clk) disable iff (rst)
        r_cube_acc <= PW'(r_y));
`endif

endmodule

// File: tb/tb_seq_cube_root.sv
// Directed bench for seq_cube_root at W=6 and W=9 with hand-computed results.
module tb_seq_cube_root;

    logic       clk = 1'b0;
    logic       rst;
    logic       start6;
    logic [5:0] y6;
    logic [1:0] root6;
    logic [5:0] rem6;
    logic       fin6;
    logic       start9;
    logic [8:0] y9;
    logic [2:0] root9;
    logic [8:0] rem9;
    logic       fin9;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_cube_root #(.W(6)) u_dut6 (
        .clk      (clk),
        .rst      (rst),
        .start    (start6),
        .y_in     (y6),
        .root_out (root6),
        .rem_out  (rem6),
        .finish   (fin6)
    );

    seq_cube_root #(.W(9)) u_dut9 (
        .clk      (clk),
        .rst      (rst),
        .start    (start9),
        .y_in     (y9),
        .root_out (root9),
        .rem_out  (rem9),
        .finish   (fin9)
    );

    function automatic int ref_root(input int y);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= y) r++;
        return r;
    endfunction

    // One W=6 operation; operand is scrambled after the accept edge.
    task automatic op6(input logic [5:0] y, input logic [1:0] er, input logic [5:0] em);
        int n;
        @(negedge clk);
        start6 = 1'b1;
        y6     = y;
        @(posedge clk);
        #1;
        start6 = 1'b0;
        y6     = ~y;
        n = 0;
        while (fin6 !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n !== 6) begin
            n_fail++;
            $display("FAIL latency6 y=%0d: got %0d cycles, expected 6", y, n);
        end
        n_checks++;
        if (root6 !== er) begin
            n_fail++;
            $display("FAIL root6 y=%0d: got %0d, expected %0d", y, root6, er);
        end
        n_checks++;
        if (rem6 !== em) begin
            n_fail++;
            $display("FAIL rem6 y=%0d: got %0d, expected %0d", y, rem6, em);
        end
    endtask

    task automatic op9(input logic [8:0] y, input logic [2:0] er, input logic [8:0] em);
        int n;
        @(negedge clk);
        start9 = 1'b1;
        y9     = y;
        @(posedge clk);
        #1;
        start9 = 1'b0;
        y9     = ~y;
        n = 0;
        while (fin9 !== 1'b1 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n !== 9) begin
            n_fail++;
            $display("FAIL latency9 y=%0d: got %0d cycles, expected 9", y, n);
        end
        n_checks++;
        if (root9 !== er) begin
            n_fail++;
            $display("FAIL root9 y=%0d: got %0d, expected %0d", y, root9, er);
        end
        n_checks++;
        if (rem9 !== em) begin
            n_fail++;
            $display("FAIL rem9 y=%0d: got %0d, expected %0d", y, rem9, em);
        end
    endtask

    task automatic test_reset();
        // start is held high during reset; reset must win
        rst    = 1'b1;
        start6 = 1'b1;
        y6     = 6'd27;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (fin6 !== 1'b1 || root6 !== 2'd0 || rem6 !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_state: finish=%b root=%0d rem=%0d, expected 1/0/0",
                     fin6, root6, rem6);
        end
        rst    = 1'b0;
        start6 = 1'b0;
        op6(6'd27, 2'd3, 6'd0);
    endtask

    task automatic test_sweep();
        op6(6'd0,  2'd0, 6'd0);
        op6(6'd7,  2'd1, 6'd6);
        op6(6'd8,  2'd2, 6'd0);
        op6(6'd26, 2'd2, 6'd18);
        op6(6'd63, 2'd3, 6'd36);
    endtask

    task automatic test_exhaustive();
        for (int y = 0; y < 64; y++) begin
            int r;
            r = ref_root(y);
            op6(6'(y), 2'(r), 6'(y - r * r * r));
        end
    endtask

    task automatic test_busy_start();
        int n;
        op6(6'd63, 2'd3, 6'd36);
        @(negedge clk);
        start6 = 1'b1;
        y6     = 6'd8;
        @(posedge clk);
        #1;
        start6 = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        start6 = 1'b1;
        y6     = 6'd1;
        @(posedge clk);
        #1;
        start6 = 1'b0;
        n = 2;
        n_checks++;
        if (fin6 !== 1'b0 || root6 !== 2'd3 || rem6 !== 6'd36) begin
            n_fail++;
            $display("FAIL busy_hold: finish=%b root=%0d rem=%0d, expected 0/3/36",
                     fin6, root6, rem6);
        end
        while (fin6 !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n !== 6 || root6 !== 2'd2 || rem6 !== 6'd0) begin
            n_fail++;
            $display("FAIL busy_result: cycles=%0d root=%0d rem=%0d, expected 6/2/0",
                     n, root6, rem6);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (fin6 !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_no_queue: finish=%b, expected 1", fin6);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        start6 = 1'b1;
        y6     = 6'd63;
        @(posedge clk);
        #1;
        y6 = 6'd8;
        n  = 0;
        while (fin6 !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n !== 6 || root6 !== 2'd3 || rem6 !== 6'd36) begin
            n_fail++;
            $display("FAIL b2b_first: cycles=%0d root=%0d rem=%0d, expected 6/3/36",
                     n, root6, rem6);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (fin6 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: finish=%b, expected 0", fin6);
        end
        n = 0;
        while (fin6 !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        start6 = 1'b0;
        n_checks++;
        if (n !== 6 || root6 !== 2'd2 || rem6 !== 6'd0) begin
            n_fail++;
            $display("FAIL b2b_second: cycles=%0d root=%0d rem=%0d, expected 6/2/0",
                     n, root6, rem6);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start6 = 1'b1;
        y6     = 6'd63;
        @(posedge clk);
        #1;
        start6 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (fin6 !== 1'b1 || root6 !== 2'd0 || rem6 !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_mid: finish=%b root=%0d rem=%0d, expected 1/0/0",
                     fin6, root6, rem6);
        end
        @(negedge clk);
        rst = 1'b0;
        op6(6'd26, 2'd2, 6'd18);
    endtask

    task automatic test_w9();
        op9(9'd511, 3'd7, 9'd168);
        op9(9'd343, 3'd7, 9'd0);
        op9(9'd342, 3'd6, 9'd126);
    endtask

    initial begin
        rst    = 1'b1;
        start6 = 1'b0;
        y6     = '0;
        start9 = 1'b0;
        y9     = '0;
        test_reset();
        test_sweep();
        test_exhaustive();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        test_w9();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/seq_cube_root.md
# seq_cube_root

Sequential integer cube-root engine: given `y_in`, it computes `root_out = floor(cbrt(y_in))` and `rem_out = y_in - root_out^3`. It is the inverse of the polynomial pipeline's sequential cube block and uses the same `start`/`finish` handshake. It sits in the polynomial pipeline as the decode stage that recovers `x` from a cubed value. The root is resolved one bit per round, MSB first, using a single shared multiplier.

## Interface
- `W`, default 6: width of `y_in`; must be ≥ 3.
- `R`, default `(W+2)/3`: root width, derived; not overridden by instantiators.
- `clk` input, 1: clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `start` input, 1: request; sampled only while `finish`=1.
- `y_in` input, W: operand; captured on the accepted `start` edge.
- `root_out` output, R: floor cube root; reset value 0.
- `rem_out` output, W: `y - root^3`; reset value 0.
- `finish` output, 1: high while idle with valid results; reset value 1.

## Operation
- **Registers:**
  - `state` in {IDLE, SQ, CU, CMP}
  - `idx` [$clog2(R)-1:0]
  - `y_reg` [W-1:0]
  - `root` [R-1:0]
  - `cube_acc` [3R-1:0]: cube of the accepted root
  - `prod` [3R-1:0]
- **Candidate:** `cand = root | (1 << idx)`, combinational.
- **IDLE:**
  - `finish`=1.
  - On `start`: `y_reg`←`y_in`, `root`←0, `cube_acc`←0, `idx`←R-1, go to SQ.
  - Otherwise all registers hold.
- **SQ:** `prod` ← `cand*cand`; go to CU.
- **CU:** `prod` ← `prod*cand`, truncated to 3R bits with no overflow possible; go to CMP.
- **CMP:**
  - If `prod` ≤ zero-extended `y_reg`: `root`←`cand` and `cube_acc`←`prod`.
  - If `idx`==0: go to IDLE. `root_out`/`rem_out` are updated from the final `root` and `y_reg - cube_acc`, including this cycle's accept.
  - Else: `idx`←`idx`-1, go to SQ.
- **Width rule:** `rem_out` is never negative and always fits in W bits, because `cube_acc` ≤ `y_reg` is invariant.
- **Output stability:** `root_out`/`rem_out` change only on the CMP→IDLE transition or on reset. They hold the previous result throughout a computation.

## Timing
- **Latency:** `start` is accepted at edge t0. `finish` is low from t0 through t0+3R-1 and high from edge t0+3R, with new results valid the same cycle. For W=6 (R=2), that is 6 cycles.
- **Back-to-back:** `start` high in the first cycle `finish` is high is accepted. Throughput is one result per 3R cycles.
- **Start while busy:** ignored; no effect on state, operand or results.
- **Input sampling:** `y_in` is sampled only at the accept edge; later changes are ignored.
- **Reset:** `rst` high at any edge, including mid-computation, forces IDLE, `root_out`=0, `rem_out`=0, `finish`=1.
  - Reset wins over a simultaneous `start`.
  - The first `start` is accepted at the edge after `rst` deasserts.
- **Flow control:** none. `finish` is the only status, and there is no output backpressure.

## Structure
- **Shared package `poly_pkg`:**
  - `cube_root_state_t` enum: IDLE, SQ, CU, CMP.
  - `function automatic int cube_root_w(int w)` returning `(w+2)/3`.
- **Single module, no sub-modules:**
  - One `R×3R` multiplier, muxed between `cand*cand` (SQ) and `prod*cand` (CU).
  - One FSM `always_ff`.
- **Assertions (inside the module, guarded for synthesis):**
  - `finish` ↔ `state==IDLE`.
  - `cube_acc` ≤ `y_reg`.

## Test plan
- **Reset:** assert `rst` for 2 cycles → `finish`=1, `root_out`=0, `rem_out`=0. Then `start`, `y_in`=27 → after exactly 6 cycles `finish`=1, `root_out`=3, `rem_out`=0.
- **Sweep, W=6:** `y_in` = 0, 7, 8, 26, 63 → (`root_out`, `rem_out`) = (0,0), (1,6), (2,0), (2,18), (3,36). `finish` is low exactly 6 cycles each. Exhaustive 0..63 checked against a reference model.
- **Back-to-back and busy start:**
  - `start` held high continuously with `y_in`=63 then 8 → results every 6 cycles.
  - `start` pulsed with `y_in`=1 mid-computation → ignored; results unchanged.
- **Reset mid-operation:** `rst` at cycle 3 of a `y_in`=63 computation → next cycle `finish`=1, outputs 0. A following `start` with `y_in`=26 → 2, 18.
- **W=9 (R=3):** `y_in`=511 → `root_out`=7, `rem_out`=168 after 9 cycles. `y_in`=343 → 7, 0. `y_in`=342 → 6, 126.
